// File: rtl/idli_enc_ser_if.sv
// Instruction-source / serialiser / decoder bus: instruction handshake plus nibble stream.
// The serialiser takes the slave modport; the instruction source and decoder side take master.
interface idli_enc_ser_if;
  typedef logic [3:0] sqi_data_t;

  logic [15:0] i_ser_ins;
  logic [15:0] i_ser_imm;
  logic        i_ser_vld;
  logic        o_ser_rdy;
  sqi_data_t   o_ser_enc;
  logic        o_ser_enc_vld;
  logic        i_ser_stall;
  logic        o_ser_busy;

  modport master (
    output i_ser_ins, i_ser_imm, i_ser_vld, i_ser_stall,
    input  o_ser_rdy, o_ser_enc, o_ser_enc_vld, o_ser_busy
  );

  modport slave (
    input  i_ser_ins, i_ser_imm, i_ser_vld, i_ser_stall,
    output o_ser_rdy, o_ser_enc, o_ser_enc_vld, o_ser_busy
  );
endinterface

// File: rtl/idli_enc_ser_m.sv
// Serialises a 16-bit instruction, plus its immediate when ins[2:0]==7, into MSB-first nibbles.
// Define IDLI_ENC_SER_SKID_EN for a one-entry holding buffer that streams words with no gap cycle.
module idli_enc_ser_m (
  input  logic          i_dcd_gck,
  input  logic          i_dcd_rst_n,
  idli_enc_ser_if.slave ser
);

  typedef enum logic [1:0] {ST_IDLE, ST_INS, ST_IMM} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] ins_q, ins_d;
  logic [15:0] imm_q, imm_d;
  logic [15:0] word;
  logic [3:0]  nib;
  logic        rdy_int;
  logic        buf_full;
  logic        xfer;

`ifdef IDLI_ENC_SER_SKID_EN
  logic        buf_vld_q, buf_vld_d;
  logic [15:0] buf_ins_q, buf_ins_d;
  logic [15:0] buf_imm_q, buf_imm_d;
  logic        took_direct;

  assign rdy_int  = ~buf_vld_q;
  assign buf_full = buf_vld_q;
`else
  assign rdy_int  = (state_q == ST_IDLE);
  assign buf_full = 1'b0;
`endif

  // Ready is forced low while reset is held so no transfer can be counted during reset.
  assign ser.o_ser_rdy = rdy_int & i_dcd_rst_n;
  assign xfer          = ser.i_ser_vld & ser.o_ser_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ins_d   = ins_q;
    imm_d   = imm_q;
`ifdef IDLI_ENC_SER_SKID_EN
    buf_vld_d   = buf_vld_q;
    buf_ins_d   = buf_ins_q;
    buf_imm_d   = buf_imm_q;
    took_direct = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d = ST_INS;
          cnt_d   = 2'd0;
          ins_d   = ser.i_ser_ins;
          imm_d   = ser.i_ser_imm;
`ifdef IDLI_ENC_SER_SKID_EN
          took_direct = 1'b1;
`endif
        end
      end
      ST_INS, ST_IMM: begin
        if (!ser.i_ser_stall) begin
          if (cnt_q != 2'd3) begin
            cnt_d = cnt_q + 2'd1;
          end else if (state_q == ST_INS && ins_q[2:0] == 3'b111) begin
            state_d = ST_IMM;
            cnt_d   = 2'd0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
`ifdef IDLI_ENC_SER_SKID_EN
            // Buffered word wins; otherwise a transfer on the last nibble is consumed directly.
            if (buf_vld_q) begin
              state_d   = ST_INS;
              ins_d     = buf_ins_q;
              imm_d     = buf_imm_q;
              buf_vld_d = 1'b0;
            end else if (xfer) begin
              state_d     = ST_INS;
              ins_d       = ser.i_ser_ins;
              imm_d       = ser.i_ser_imm;
              took_direct = 1'b1;
            end
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
`ifdef IDLI_ENC_SER_SKID_EN
    if (xfer && !took_direct) begin
      buf_vld_d = 1'b1;
      buf_ins_d = ser.i_ser_ins;
      buf_imm_d = ser.i_ser_imm;
    end
`endif
  end

  always_comb begin
    word = (state_q == ST_IMM) ? imm_q : ins_q;
    case (cnt_q)
      2'd0:    nib = word[15:12];
      2'd1:    nib = word[11:8];
      2'd2:    nib = word[7:4];
      default: nib = word[3:0];
    endcase
  end

  assign ser.o_ser_enc     = (state_q != ST_IDLE) ? nib : 4'h0;
  assign ser.o_ser_enc_vld = (state_q != ST_IDLE) && !ser.i_ser_stall;
  assign ser.o_ser_busy    = (state_q != ST_IDLE) || buf_full;

  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      ins_q   <= 16'h0000;
      imm_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      imm_q   <= imm_d;
    end
  end

`ifdef IDLI_ENC_SER_SKID_EN
  always_ff @(posedge i_dcd_gck or negedge i_dcd_rst_n) begin
    if (!i_dcd_rst_n) begin
      buf_vld_q <= 1'b0;
      buf_ins_q <= 16'h0000;
      buf_imm_q <= 16'h0000;
    end else begin
      buf_vld_q <= buf_vld_d;
      buf_ins_q <= buf_ins_d;
      buf_imm_q <= buf_imm_d;
    end
  end
`endif

endmodule

// File: tb/tb_idli_enc_ser_m.sv
// Bench for idli_enc_ser_m: directed timing steps plus a nibble scoreboard fed on every transfer.
// Build-dependent expectations follow IDLI_ENC_SER_SKID_EN.
module tb_idli_enc_ser_m;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [3:0] sb_q[$];

  idli_enc_ser_if ser_if ();

  idli_enc_ser_m dut (
    .i_dcd_gck   (clk),
    .i_dcd_rst_n (rst_n),
    .ser         (ser_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Every accepted instruction queues its nibbles (and immediate's); every valid nibble pops one.
  always @(negedge clk) begin
    logic [3:0] exp_n;
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (ser_if.o_ser_enc_vld) begin
        if (sb_q.size() == 0) begin
          check_output("sb_nibble_expected", 16'(sb_q.size() != 0), 16'd1);
        end else begin
          exp_n = sb_q.pop_front();
          check_output("sb_nibble", {12'h000, ser_if.o_ser_enc}, {12'h000, exp_n});
        end
      end
      if (ser_if.i_ser_vld && ser_if.o_ser_rdy) begin
        for (int i = 3; i >= 0; i--) sb_q.push_back(ser_if.i_ser_ins[4*i +: 4]);
        if (ser_if.i_ser_ins[2:0] == 3'b111)
          for (int i = 3; i >= 0; i--) sb_q.push_back(ser_if.i_ser_imm[4*i +: 4]);
      end
    end
  end

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] ins, input logic [15:0] imm, input string tag);
    ser_if.i_ser_vld = 1'b1;
    ser_if.i_ser_ins = ins;
    ser_if.i_ser_imm = imm;
    @(negedge clk);
    check_output({tag, "_rdy"}, 16'(ser_if.o_ser_rdy), 16'd1);
    next_edge();
    ser_if.i_ser_vld = 1'b0;
  endtask

  task automatic expect_cyc(input string tag, input logic v, input logic [3:0] e);
    @(negedge clk);
    check_output({tag, "_vld"}, 16'(ser_if.o_ser_enc_vld), 16'(v));
    check_output({tag, "_enc"}, {12'h000, ser_if.o_ser_enc}, {12'h000, e});
    next_edge();
  endtask

  initial begin
    logic [3:0] t4_nib[10];
    logic       t4_vld[10];
    logic       acc;
    logic       second_taken;
    int         sent;
    int         cycles;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ser_if.i_ser_vld   = 1'b0;
    ser_if.i_ser_stall = 1'b0;
    ser_if.i_ser_ins   = 16'h0000;
    ser_if.i_ser_imm   = 16'h0000;

    // Reset state
    repeat (2) next_edge();
    @(negedge clk);
    check_output("rst_rdy", 16'(ser_if.o_ser_rdy), 16'd0);
    check_output("rst_vld", 16'(ser_if.o_ser_enc_vld), 16'd0);
    check_output("rst_enc", {12'h000, ser_if.o_ser_enc}, 16'h0000);
    check_output("rst_busy", 16'(ser_if.o_ser_busy), 16'd0);
    next_edge();
    rst_n = 1'b1;

    // Plain instruction
    apply_stimulus(16'hC123, 16'h0000, "t1");
    expect_cyc("t1_n0", 1'b1, 4'hC);
    expect_cyc("t1_n1", 1'b1, 4'h1);
    expect_cyc("t1_n2", 1'b1, 4'h2);
    expect_cyc("t1_n3", 1'b1, 4'h3);
    @(negedge clk);
    check_output("t1_idle_busy", 16'(ser_if.o_ser_busy), 16'd0);
    expect_cyc("t1_idle", 1'b0, 4'h0);

    // Instruction with immediate
    apply_stimulus(16'hC127, 16'hBEEF, "t2");
    expect_cyc("t2_n0", 1'b1, 4'hC);
    expect_cyc("t2_n1", 1'b1, 4'h1);
    expect_cyc("t2_n2", 1'b1, 4'h2);
    expect_cyc("t2_n3", 1'b1, 4'h7);
    expect_cyc("t2_n4", 1'b1, 4'hB);
    expect_cyc("t2_n5", 1'b1, 4'hE);
    expect_cyc("t2_n6", 1'b1, 4'hE);
    expect_cyc("t2_n7", 1'b1, 4'hF);
    expect_cyc("t2_idle", 1'b0, 4'h0);

    // Stall on the second nibble
    apply_stimulus(16'h5A3C, 16'h0000, "t3");
    expect_cyc("t3_n0", 1'b1, 4'h5);
    ser_if.i_ser_stall = 1'b1;
    expect_cyc("t3_stall", 1'b0, 4'hA);
    ser_if.i_ser_stall = 1'b0;
    expect_cyc("t3_n1", 1'b1, 4'hA);
    expect_cyc("t3_n2", 1'b1, 4'h3);
    expect_cyc("t3_n3", 1'b1, 4'hC);
    expect_cyc("t3_idle", 1'b0, 4'h0);

    // Two instructions offered back to back
`ifdef IDLI_ENC_SER_SKID_EN
    t4_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    t4_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0, 4'h0};
`else
    t4_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t4_nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 4'h5, 4'h6, 4'h7, 4'h8, 4'h0};
`endif
    apply_stimulus(16'h1234, 16'h0000, "t4a");
    ser_if.i_ser_vld = 1'b1;
    ser_if.i_ser_ins = 16'h5678;
    second_taken = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output($sformatf("t4_c%0d_vld", k), 16'(ser_if.o_ser_enc_vld), 16'(t4_vld[k]));
      check_output($sformatf("t4_c%0d_enc", k), {12'h000, ser_if.o_ser_enc}, {12'h000, t4_nib[k]});
      acc = ser_if.i_ser_vld && ser_if.o_ser_rdy;
      next_edge();
      if (acc) begin
        second_taken     = 1'b1;
        ser_if.i_ser_vld = 1'b0;
      end
    end
    ser_if.i_ser_vld = 1'b0;
    check_output("t4_second_taken", 16'(second_taken), 16'd1);

    // Reset in the middle of an instruction that carries an immediate
    apply_stimulus(16'hABC7, 16'h1111, "t5");
    expect_cyc("t5_n0", 1'b1, 4'hA);
    expect_cyc("t5_n1", 1'b1, 4'hB);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("t5_rst_vld", 16'(ser_if.o_ser_enc_vld), 16'd0);
    check_output("t5_rst_enc", {12'h000, ser_if.o_ser_enc}, 16'h0000);
    check_output("t5_rst_busy", 16'(ser_if.o_ser_busy), 16'd0);
    check_output("t5_rst_rdy", 16'(ser_if.o_ser_rdy), 16'd0);
    next_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check_output("t5_rel_rdy", 16'(ser_if.o_ser_rdy), 16'd1);
    next_edge();
    for (int k = 0; k < 10; k++) expect_cyc($sformatf("t5_quiet%0d", k), 1'b0, 4'h0);

    // Long random run: vld held high, random stalls, random immediates
    sent   = 0;
    cycles = 0;
    ser_if.i_ser_vld = 1'b1;
    ser_if.i_ser_ins = 16'($urandom);
    if ($urandom_range(0, 2) == 0) ser_if.i_ser_ins[2:0] = 3'b111;
    ser_if.i_ser_imm = 16'($urandom);
    while (sent < 1000 && cycles < 60000) begin
      ser_if.i_ser_stall = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      acc = ser_if.i_ser_vld && ser_if.o_ser_rdy;
      next_edge();
      cycles++;
      if (acc) begin
        sent++;
        ser_if.i_ser_ins = 16'($urandom);
        if ($urandom_range(0, 2) == 0) ser_if.i_ser_ins[2:0] = 3'b111;
        ser_if.i_ser_imm = 16'($urandom);
      end
    end
    ser_if.i_ser_vld   = 1'b0;
    ser_if.i_ser_stall = 1'b0;
    check_output("t6_sent", 16'(sent), 16'd1000);
    while (sb_q.size() != 0 && cycles < 70000) begin
      next_edge();
      cycles++;
    end
    check_output("t6_drained", 16'(sb_q.size()), 16'd0);
    next_edge();
    @(negedge clk);
    check_output("t6_end_busy", 16'(ser_if.o_ser_busy), 16'd0);
    check_output("t6_end_vld", 16'(ser_if.o_ser_enc_vld), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
